// File: rtl/var_gen_lanes_pkg.sv
// Shared types and helper functions for the unary-path variable generator.
package var_gen_pkg;

   typedef enum logic [1:0] {
      MODE_GEMM = 2'b00,
      MODE_DIV  = 2'b01,
      MODE_EXP  = 2'b10,
      MODE_LOG  = 2'b11
   } mode_e;

   // 0.75 in Q.fra_bw, i.e. 2'b11 at bits [fra_bw-1:fra_bw-2], clipped to mul_bw bits
   function automatic int point_val(input int fra_bw, input int mul_bw);
      int v;
      v = 3 << (fra_bw - 2);
      if (mul_bw < 31) begin
         v = v & ((1 << mul_bw) - 1);
      end
      return v;
   endfunction

   function automatic int shift_width(input int mul_bw);
      return $clog2(mul_bw) + 1;
   endfunction

endpackage

// File: rtl/var_gen_lanes_lead_one_det.sv
// Leading-one detector: index of the highest set bit of m, plus an all-zero flag.
module lead_one_det #(
   parameter int W  = 16,
   parameter int PW = $clog2(W)
) (
   input  logic [W-1:0]  m,
   output logic [PW-1:0] p,
   output logic          zero
);

   // Ascending scan so the highest set bit wins
   always_comb begin
      p = '0;
      for (int i = 0; i < W; i++) begin
         if (m[i]) p = PW'(i);
      end
   end

   assign zero = (m == '0);

endmodule

// File: rtl/var_gen_lanes.sv
// LANES-wide 2-stage variable generator for the div/exp/log unary path.
// Optional zero_o flag port and zero-magnitude handling under VAR_GEN_ZERO_FLAG_EN.
module var_gen_lanes
   import var_gen_pkg::*;
#(
   parameter int LANES  = 4,
   parameter int INT_BW = 5,
   parameter int FRA_BW = 10,
   parameter int MUL_BW = 16
) (
   input  logic                                         clk,
   input  logic                                         rst,
   input  logic                                         in_vld,
   output logic                                         in_rdy,
   input  logic [1:0]                                   mode_i,
   input  logic [LANES*MUL_BW-1:0]                      x_i,
   output logic                                         out_vld,
   input  logic                                         out_rdy,
   output logic [LANES*MUL_BW-1:0]                      var_o,
   output logic [LANES*shift_width(MUL_BW)-1:0]         shift_o,
   output logic [LANES*(INT_BW+1)-1:0]                  int_o,
   output logic [LANES-1:0]                             sign_o
`ifdef VAR_GEN_ZERO_FLAG_EN
   ,
   output logic [LANES-1:0]                             zero_o
`endif
);

   localparam int SH_BW = shift_width(MUL_BW);
   localparam int PW    = $clog2(MUL_BW);
   localparam logic [MUL_BW-1:0] POINT   = MUL_BW'(point_val(FRA_BW, MUL_BW));
   localparam logic [MUL_BW-1:0] MAG_MAX = {1'b0, {(MUL_BW-1){1'b1}}};
   localparam logic [MUL_BW-1:0] MOST_NEG = {1'b1, {(MUL_BW-1){1'b0}}};

   if (MUL_BW != 1 + INT_BW + FRA_BW) begin : g_cfg_err
      $error("var_gen_lanes: MUL_BW must equal 1+INT_BW+FRA_BW");
   end

   // Handshake: a beat moves across an interface on a rising edge where its
   // valid and ready are both high; valid never waits for ready, and S2 holds
   // its contents unchanged while out_vld is high and out_rdy is low.
   logic  s1_vld, s2_vld;
   logic  s2_free, s1_load;
   mode_e s1_mode;

   assign s2_free = !s2_vld || out_rdy;
   assign in_rdy  = !rst && (!s1_vld || s2_free);
   assign s1_load = in_vld && in_rdy;
   assign out_vld = s2_vld;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_vld  <= 1'b0;
         s2_vld  <= 1'b0;
         s1_mode <= MODE_GEMM;
      end else begin
         if (in_rdy)  s1_vld  <= in_vld;
         if (s1_load) s1_mode <= mode_e'(mode_i);
         if (s2_free) s2_vld  <= s1_vld;
      end
   end

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic [MUL_BW-1:0] x_c, m_c;
      logic [PW-1:0]     p_c;
      logic              lz_c;
      logic [SH_BW-1:0]  sh_c;

      logic [MUL_BW-1:0] s1_x, s1_m;
      logic [SH_BW-1:0]  s1_sh;

      logic [SH_BW-1:0]  neg_sh;
      logic [MUL_BW-1:0] norm_c, var_c;
      logic [SH_BW-1:0]  sho_c;

      logic [MUL_BW-1:0] s2_var;
      logic [SH_BW-1:0]  s2_sh;
      logic [INT_BW:0]   s2_int;
      logic              s2_sign;

      assign x_c = x_i[l*MUL_BW +: MUL_BW];

      // The most negative input has no positive twin; clamp it to the max magnitude
      always_comb begin
         m_c = x_c;
         if (x_c[MUL_BW-1]) begin
            m_c = (x_c == MOST_NEG) ? MAG_MAX : (~x_c + MUL_BW'(1));
         end
      end

      lead_one_det #(.W(MUL_BW), .PW(PW)) u_lod (
         .m    (m_c),
         .p    (p_c),
         .zero (lz_c)
      );

      assign sh_c = lz_c ? '0 : (SH_BW'(FRA_BW - 1) - SH_BW'(p_c));

`ifdef VAR_GEN_ZERO_FLAG_EN
      logic s1_zero;
      logic zero_c;
      logic s2_zero;
`endif

      always_ff @(posedge clk) begin
         if (rst) begin
            s1_x  <= '0;
            s1_m  <= '0;
            s1_sh <= '0;
`ifdef VAR_GEN_ZERO_FLAG_EN
            s1_zero <= 1'b0;
`endif
         end else if (s1_load) begin
            s1_x  <= x_c;
            s1_m  <= m_c;
            s1_sh <= sh_c;
`ifdef VAR_GEN_ZERO_FLAG_EN
            s1_zero <= lz_c;
`endif
         end
      end

      // Negative shift means the leading one sits above FRA_BW-1: shift right
      assign neg_sh = -s1_sh;
      assign norm_c = s1_sh[SH_BW-1] ? (s1_m >> neg_sh) : (s1_m << s1_sh);

      always_comb begin
         var_c = '0;
         sho_c = '0;
`ifdef VAR_GEN_ZERO_FLAG_EN
         zero_c = 1'b0;
`endif
         case (s1_mode)
            MODE_DIV, MODE_LOG: begin
               var_c = POINT - norm_c;
               sho_c = s1_sh;
`ifdef VAR_GEN_ZERO_FLAG_EN
               zero_c = s1_zero;
               if (s1_zero) var_c = '0;
`else
`endif
            end
            MODE_EXP: begin
               var_c = {{(INT_BW+1){s1_x[MUL_BW-1]}}, s1_x[FRA_BW-1:0]};
            end
            default: begin
            end
         endcase
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            s2_var  <= '0;
            s2_sh   <= '0;
            s2_int  <= '0;
            s2_sign <= 1'b0;
`ifdef VAR_GEN_ZERO_FLAG_EN
            s2_zero <= 1'b0;
`endif
         end else if (s2_free && s1_vld) begin
            s2_var  <= var_c;
            s2_sh   <= sho_c;
            s2_int  <= s1_x[MUL_BW-1:FRA_BW];
            s2_sign <= s1_x[MUL_BW-1];
`ifdef VAR_GEN_ZERO_FLAG_EN
            s2_zero <= zero_c;
`endif
         end
      end

      assign var_o[l*MUL_BW +: MUL_BW]         = s2_var;
      assign shift_o[l*SH_BW +: SH_BW]         = s2_sh;
      assign int_o[l*(INT_BW+1) +: (INT_BW+1)] = s2_int;
      assign sign_o[l]                         = s2_sign;
`ifdef VAR_GEN_ZERO_FLAG_EN
      assign zero_o[l]                         = s2_zero;
`endif
   end

endmodule

// File: tb/tb_var_gen_lanes.sv
// Directed self-checking bench for var_gen_lanes (default parameters).
// Build with VAR_GEN_ZERO_FLAG_EN defined to also check zero_o.
module tb_var_gen_lanes;

   localparam int LANES  = 4;
   localparam int INT_BW = 5;
   localparam int FRA_BW = 10;
   localparam int MUL_BW = 16;
   localparam int SH_BW  = 5;

   logic                        clk;
   logic                        rst;
   logic                        in_vld;
   logic                        in_rdy;
   logic [1:0]                  mode_i;
   logic [LANES*MUL_BW-1:0]     x_i;
   logic                        out_vld;
   logic                        out_rdy;
   logic [LANES*MUL_BW-1:0]     var_o;
   logic [LANES*SH_BW-1:0]      shift_o;
   logic [LANES*(INT_BW+1)-1:0] int_o;
   logic [LANES-1:0]            sign_o;
`ifdef VAR_GEN_ZERO_FLAG_EN
   logic [LANES-1:0]            zero_o;
`endif

   int checks = 0;
   int errors = 0;
   logic [LANES*MUL_BW-1:0] exp_q[$];

   var_gen_lanes #(
      .LANES(LANES), .INT_BW(INT_BW), .FRA_BW(FRA_BW), .MUL_BW(MUL_BW)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .in_vld  (in_vld),
      .in_rdy  (in_rdy),
      .mode_i  (mode_i),
      .x_i     (x_i),
      .out_vld (out_vld),
      .out_rdy (out_rdy),
      .var_o   (var_o),
      .shift_o (shift_o),
      .int_o   (int_o),
      .sign_o  (sign_o)
`ifdef VAR_GEN_ZERO_FLAG_EN
      ,
      .zero_o  (zero_o)
`endif
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed=no_finish expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   // driver: wait (bounded) until the presented beat is accepted
   task automatic wait_accept(input string tag);
      int n = 0;
      #1;
      while (!in_rdy && n < 20) begin
         @(negedge clk); #1;
         n++;
      end
      check(tag, 64'(in_rdy), 64'd1);
   endtask

   // one isolated beat: checks 2-clock latency and all outputs
   task automatic run_beat(input string tag, input logic [1:0] m, input logic [63:0] x,
                           input logic [63:0] ev, input logic [19:0] es,
                           input logic [23:0] ei, input logic [3:0] esg,
                           input logic [3:0] ez);
      @(negedge clk);
      in_vld = 1'b1; mode_i = m; x_i = x;
      wait_accept({tag, "_rdy"});
      @(negedge clk);
      in_vld = 1'b0; #1;
      check({tag, "_lat1"}, 64'(out_vld), 64'd0);
      @(negedge clk); #1;
      check({tag, "_vld"},   64'(out_vld), 64'd1);
      check({tag, "_var"},   var_o,        ev);
      check({tag, "_shift"}, 64'(shift_o), 64'(es));
      check({tag, "_int"},   64'(int_o),   64'(ei));
      check({tag, "_sign"},  64'(sign_o),  64'(esg));
`ifdef VAR_GEN_ZERO_FLAG_EN
      check({tag, "_zero"},  64'(zero_o),  64'(ez));
`else
      if (ez != 4'h0) check({tag, "_zero_nocfg"}, 64'(var_o[63:48]), 64'h0300);
`endif
   endtask

   initial begin
      logic [63:0] v;
      int got;
      int cyc;

      rst = 1'b1; in_vld = 1'b0; out_rdy = 1'b1; mode_i = 2'b00; x_i = '0;
      repeat (3) @(negedge clk);
      #1;
      check("rst_in_rdy",  64'(in_rdy),  64'd0);
      check("rst_out_vld", 64'(out_vld), 64'd0);
      rst = 1'b0;
      @(negedge clk); #1;
      check("post_rst_in_rdy", 64'(in_rdy),  64'd1);
      check("post_rst_vld",    64'(out_vld), 64'd0);
      check("post_rst_var",    var_o,        64'd0);
      check("post_rst_shift",  64'(shift_o), 64'd0);
      check("post_rst_int",    64'(int_o),   64'd0);
      check("post_rst_sign",   64'(sign_o),  64'd0);

      // div: 1.0, 0.25, most-negative, zero
`ifdef VAR_GEN_ZERO_FLAG_EN
      v = {16'h0000, 16'hFF01, 16'h0100, 16'h0100};
`else
      v = {16'h0300, 16'hFF01, 16'h0100, 16'h0100};
`endif
      run_beat("div", 2'b01, {16'h0000, 16'h8000, 16'h0100, 16'h0400}, v,
               {5'h00, 5'h1B, 5'h01, 5'h1F}, {6'h00, 6'h20, 6'h00, 6'h01},
               4'b0100, 4'b1000);

      // log: 0.25, -1.0, 1 lsb, max positive
      run_beat("log", 2'b11, {16'h7FFF, 16'h0001, 16'hFC00, 16'h0100},
               {16'hFF01, 16'h0100, 16'h0100, 16'h0100},
               {5'h1B, 5'h09, 5'h1F, 5'h01}, {6'h1F, 6'h00, 6'h3F, 6'h00},
               4'b0010, 4'b0000);

      // exp: sign-extended fraction, shift forced to 0
      run_beat("exp", 2'b10, {16'h8000, 16'h0000, 16'hFE00, 16'h0C80},
               {16'hFC00, 16'h0000, 16'hFE00, 16'h0080},
               20'h0, {6'h20, 6'h00, 6'h3F, 6'h03}, 4'b1010, 4'b0000);

      // gemm: var/shift zero, int/sign still reported
      run_beat("gemm", 2'b00, {16'h0000, 16'h0400, 16'hFFFF, 16'h1234},
               64'h0, 20'h0, {6'h00, 6'h01, 6'h3F, 6'h04}, 4'b0010, 4'b0000);

      // streaming: 8 back-to-back exp beats with a 3-clock out_rdy stall
      got = 0;
      fork
         begin : drv
            for (int k = 0; k < 8; k++) begin
               @(negedge clk);
               in_vld = 1'b1; mode_i = 2'b10;
               for (int j = 0; j < LANES; j++) x_i[j*MUL_BW +: MUL_BW] = 16'(k*16 + j + 1);
               wait_accept("stream_rdy");
               exp_q.push_back(x_i);
            end
            @(negedge clk);
            in_vld = 1'b0;
         end
         begin : rdy_ctl
            repeat (4) @(negedge clk);
            out_rdy = 1'b0;
            repeat (3) @(negedge clk);
            out_rdy = 1'b1;
         end
         begin : mon
            cyc = 0;
            while (got < 8 && cyc < 100) begin
               @(negedge clk); #2;
               cyc++;
               if (out_vld && exp_q.size() == 0) begin
                  check("stream_dup", 64'(exp_q.size()), 64'd1);
               end else if (out_vld && !out_rdy) begin
                  check("stream_hold", var_o, exp_q[0]);
               end else if (out_vld && out_rdy) begin
                  check("stream_data", var_o, exp_q.pop_front());
                  got++;
               end
            end
         end
      join
      check("stream_count", 64'(got), 64'd8);
      check("stream_left",  64'(exp_q.size()), 64'd0);
      @(negedge clk); #1;
      check("stream_idle", 64'(out_vld), 64'd0);

      // reset with one beat in S2 and one in S1
      out_rdy = 1'b0;
      @(negedge clk);
      in_vld = 1'b1; mode_i = 2'b01; x_i = {4{16'h0400}};
      wait_accept("mid_rdy_a");
      @(negedge clk);
      x_i = {4{16'h0100}};
      wait_accept("mid_rdy_b");
      @(negedge clk);
      in_vld = 1'b0; #1;
      check("mid_pre_vld", 64'(out_vld), 64'd1);
      rst = 1'b1; #1;
      check("mid_rst_rdy", 64'(in_rdy), 64'd0);
      @(negedge clk);
      rst = 1'b0; out_rdy = 1'b1; #1;
      check("mid_vld",   64'(out_vld), 64'd0);
      check("mid_var",   var_o,        64'd0);
      check("mid_shift", 64'(shift_o), 64'd0);
      check("mid_int",   64'(int_o),   64'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         check("mid_quiet", 64'(out_vld), 64'd0);
      end
      run_beat("post_mid", 2'b10, {16'h0001, 16'h0002, 16'h0003, 16'h0C80},
               {16'h0001, 16'h0002, 16'h0003, 16'h0080},
               20'h0, {6'h00, 6'h00, 6'h00, 6'h03}, 4'b0000, 4'b0000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
